// File: rtl/chunked_add_seq_pkg.sv
// Shared definitions for the chunked wide-adder sequencer: FSM encoding and
// the ceil-log2 helper used to size the slice index.
package chunked_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunked_add_seq_add_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out; the
// sequencer reuses a single instance for every slice of the wide add.
module add_chunk #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock, carry held in a
// register. Optional CIN/COUT ports are enabled by `define CHUNKED_ADD_CARRY_EN.
module chunked_add_seq
    import chunked_add_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int CHUNK = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] SUM
`ifdef CHUNKED_ADD_CARRY_EN
    ,
    input  logic             CIN,
    output logic             COUT
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? clog2_f(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q, sum_d;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ready_q, res_valid_q;
    logic               cin_w;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_co;

`ifdef CHUNKED_ADD_CARRY_EN
    logic               cout_q;
    assign cin_w = CIN;
    assign COUT  = cout_q;
`else
    assign cin_w = 1'b0;
`endif

    add_chunk #(.CHUNK(CHUNK)) u_add (
        .a  (a_q[CHUNK-1:0]),
        .b  (b_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // New slice enters at the MSB end so the lowest slice lands at bit 0 last.
    assign sum_d = WIDTH'({slice_s, sum_q} >> CHUNK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
`ifdef CHUNKED_ADD_CARRY_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= cin_w;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_co;
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    idx_q   <= idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
`ifdef CHUNKED_ADD_CARRY_EN
                        cout_q      <= slice_co;
`endif
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = ready_q;
    assign RES_VALID = res_valid_q;
    assign SUM       = sum_q;

endmodule
